imem_boot_loader: RTL and testbench

//  Loads the program image into the 256-word instruction memory from a byte stream
//  (UART receiver / debug link). Holds the core in reset until loading completes.

---
 rtl/imem_boot_loader.sv | 212 +++++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed little-endian word stream, writes it into
// instruction memory, pads the remainder with NOP and then releases the core reset.
module imem_boot_loader #(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned     CNT_W   = ADDR_W + 1;
    localparam logic [16:0]     DEPTH_N = 17'd1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST    = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_FILL,
        S_RUN,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        bcnt_q, bcnt_d;

    logic              rx_ready_q, rx_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [15:0]       n_full;
    logic [CNT_W-1:0]  idx_inc;

    assign accept  = rx_valid & rx_ready_q;
    assign n_full  = {rx_data, n_q[7:0]};
    assign idx_inc = idx_q + CNT_ONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            idx_q       <= '0;
            fill_q      <= '0;
            word_q      <= '0;
            bcnt_q      <= '0;
            rx_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            fill_q      <= fill_d;
            word_q      <= word_d;
            bcnt_q      <= bcnt_d;
            rx_ready_q  <= rx_ready_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        fill_d  = fill_q;
        word_d  = word_q;
        bcnt_d  = bcnt_q;
        unique case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) begin
                    state_d = S_HDR0;
                end
            end
            S_HDR0: begin
                if (accept) begin
                    n_d     = {8'h00, rx_data};
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    n_d    = n_full;
                    idx_d  = '0;
                    bcnt_d = '0;
                    if ({1'b0, n_full} > DEPTH_N) begin
                        state_d = S_ERR;
                    end else if (n_full == 16'd0) begin
                        fill_d  = '0;
                        state_d = S_FILL;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // Bytes enter at the top so the first (LSB) byte ends up in [7:0].
                if (accept) begin
                    word_d = {rx_data, word_q[31:8]};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                idx_d = idx_inc;
                if (17'(idx_inc) == {1'b0, n_q}) begin
                    if ({1'b0, n_q} == DEPTH_N) begin
                        state_d = S_RUN;
                    end else begin
                        fill_d  = idx_inc;
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_FILL: begin
                if (fill_q == LAST) begin
                    state_d = S_RUN;
                end else begin
                    fill_d = fill_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        rx_ready_d  = 1'b0;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        cpu_rst_n_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        unique case (state_d)
            S_HDR0, S_HDR1, S_DATA: begin
                rx_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            S_WRITE: begin
                we_d    = 1'b1;
                waddr_d = idx_q[ADDR_W-1:0];
                wdata_d = word_d;
                busy_d  = 1'b1;
            end
            S_FILL: begin
                we_d    = 1'b1;
                waddr_d = fill_d[ADDR_W-1:0];
                wdata_d = NOP_WORD;
                busy_d  = 1'b1;
            end
            S_RUN: begin
                cpu_rst_n_d = 1'b1;
                done_d      = 1'b1;
            end
            S_ERR: begin
                err_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign rx_ready    = rx_ready_q;
    assign imem_we     = we_q;
    assign imem_waddr  = waddr_q;
    assign imem_wdata  = wdata_q;
    assign cpu_reset_n = cpu_rst_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected IMEM writes are queued by the
// stimulus and consumed by a monitor that watches imem_we.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_reset_n;
    logic        busy;
    logic        done;
    logic        err;

    imem_boot_loader #(
        .ADDR_W   (8),
        .NOP_WORD (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .cpu_reset_n (cpu_reset_n),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          gap;   // exact cycles since previous write, 0 = unconstrained
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic monitor();
        int unsigned last = 0;
        wr_t e;
        forever begin
            @(negedge clk);
            if (reset_n && imem_we) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                             imem_waddr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(imem_waddr), 32'(e.addr));
                    check("write_data", imem_wdata, e.data);
                    if (e.gap != 0) check("write_spacing", cyc - last, 32'(e.gap));
                end
                last = cyc;
            end
        end
    endtask

    task automatic push_wr(input int addr, input logic [31:0] data, input int gap);
        exp_q.push_back('{8'(addr), data, gap});
    endtask

    task automatic push_fill(input int from);
        for (int a = from; a < 256; a++) push_wr(a, 32'h0000_0013, (a != 0) ? 1 : 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted, rx_valid left high.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            tests++;
            fails++;
            $display("FAIL rx_ready_timeout: got rx_ready=0 for %0d cycles, expected 1", n);
        end
        @(negedge clk);
    endtask

    task automatic send_gap(input logic [7:0] b);
        rx_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_byte(b);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("done", 32'(done), 32'd1);
        check("cpu_reset_n_run", 32'(cpu_reset_n), 32'd1);
        check("busy_run", 32'(busy), 32'd0);
        check("writes_outstanding", exp_q.size(), 32'd0);
    endtask

    task automatic load_n2(input bit gaps, input bit start_in_fill);
        logic [7:0] v[10] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                              8'h13, 8'h01, 8'h20, 8'h00};
        push_wr(0, 32'h0010_0093, 0);
        push_wr(1, 32'h0020_0113, 0);
        push_fill(2);
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            if (gaps) send_gap(v[i]);
            else      send_byte(v[i]);
        end
        rx_valid = 1'b0;
        if (start_in_fill) begin
            repeat (30) @(negedge clk);
            pulse_start();
            check("start_in_fill_busy", 32'(busy), 32'd1);
        end
        wait_done();
    endtask

    initial begin
        logic [7:0] iv;
        fork
            monitor();
        join_none

        // Reset values
        #12;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_waddr", 32'(imem_waddr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_rx_ready", 32'(rx_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);

        // N=2 with back-to-back bytes
        load_n2(1'b0, 1'b0);

        // N=0: whole memory filled
        push_fill(0);
        pulse_start();
        check("run_to_hdr_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        check("run_to_hdr_busy", 32'(busy), 32'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        rx_valid = 1'b0;
        wait_done();

        // N=256, back-to-back: one word per 5 cycles, no fill
        for (int i = 0; i < 256; i++) begin
            iv = 8'(i);
            push_wr(i, {iv, 8'hC3, ~iv, 8'h3C}, (i == 0) ? 0 : 5);
        end
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        for (int i = 0; i < 256; i++) begin
            iv = 8'(i);
            send_byte(8'h3C);
            send_byte(~iv);
            send_byte(8'hC3);
            send_byte(iv);
        end
        rx_valid = 1'b0;
        wait_done();

        // N=257 -> error, no writes
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        rx_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("err_set", 32'(err), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        check("err_done", 32'(done), 32'd0);
        check("err_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        check("err_rx_ready", 32'(rx_ready), 32'd0);
        push_wr(0, 32'hDEAD_BEEF, 0);
        push_fill(1);
        pulse_start();
        check("err_cleared", 32'(err), 32'd0);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        rx_valid = 1'b0;
        wait_done();

        // N=2 with random rx_valid gaps
        load_n2(1'b1, 1'b0);

        // Reset during DATA after two data bytes
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h93);
        send_byte(8'h00);
        rx_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("midrst_imem_we", 32'(imem_we), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        check("midrst_rx_ready", 32'(rx_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle_rx_ready", 32'(rx_ready), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);

        // Reload, with a start pulse during FILL that must be ignored
        load_n2(1'b0, 1'b1);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
